// File: rtl/rv_mc_sequencer_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rv_mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd7
    } state_t;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/rv_mc_sequencer_if.sv
// Instruction and data memory req/ready handshake bundle.
// Latency: n/a (wires only).
// Backpressure: requester holds req until the memory answers with ready.
interface rv_mc_sequencer_if #(
    parameter int INST_LENGTH = 32
);
    logic                   imem_req;
    logic                   imem_ready;
    logic [INST_LENGTH-1:0] imem_rdata;
    logic                   dmem_req;
    logic                   dmem_we;
    logic                   dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, imem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, imem_rdata, dmem_ready
    );
endinterface

// File: rtl/rv_mc_wait_timer.sv
// Memory wait counter shared by the FETCH and MEM states.
// Latency: timeout is combinational in the cycle the count would reach MEM_TIMEOUT.
// Backpressure: counts cycles with req high and ready low; MEM_TIMEOUT=0 never fires.
module rv_mc_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    output logic timeout
);
    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] cnt;
    logic          waiting;

    assign waiting = req && !ready;

    // Any cycle that is not a stalled request restarts the count, which covers
    // every entry into FETCH or MEM.
    always_ff @(posedge clk) begin
        if (rst || !waiting) begin
            cnt <= '0;
        end else if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + CW'(1);
        end
    end

    generate
        if (MEM_TIMEOUT == 0) begin : g_no_timeout
            assign timeout = 1'b0;
        end else begin : g_timeout
            assign timeout = waiting && (cnt == CW'(MEM_TIMEOUT - 1));
        end
    endgenerate
endmodule

// File: rtl/rv_mc_sequencer.sv
// Multi-cycle RV32I control sequencer: PC/IR owner, FETCH-DECODE-EXECUTE-MEM-WRITEBACK.
// Latency: ALU/store 4 cycles, load 5, plus one per memory wait cycle.
// Backpressure: imem/dmem req held until ready; stall beyond MEM_TIMEOUT traps. Option: RV_MC_PERF_COUNTERS_EN.
module rv_mc_sequencer
    import rv_mc_pkg::*;
#(
    parameter int                   PC_LENGTH   = 32,
    parameter int                   INST_LENGTH = 32,
    parameter logic [PC_LENGTH-1:0] RESET_PC    = PC_LENGTH'(DEFAULT_RESET_PC),
    parameter int                   MEM_TIMEOUT = 16,
    parameter int                   CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_LENGTH-1:0]   pc_next,
    output logic [PC_LENGTH-1:0]   pc,
    output logic [INST_LENGTH-1:0] ir,
    rv_mc_sequencer_if.master      mem,
    input  logic                   dec_mem_en,
    input  logic                   dec_mem_wr,
    input  logic                   dec_reg_we,
    input  logic                   dec_illegal,
    output logic                   alu_q_we,
    output logic                   mdr_we,
    output logic                   reg_we,
    output logic                   retire,
    output logic                   trap,
    output logic [2:0]             state_o
`ifdef RV_MC_PERF_COUNTERS_EN
    ,
    output logic [CNT_WIDTH-1:0]   cycle_cnt,
    output logic [CNT_WIDTH-1:0]   instret_cnt
`endif
);
    state_t state;
    logic   in_fetch, in_mem, wait_ready, timeout;

    assign in_fetch   = (state == S_FETCH);
    assign in_mem     = (state == S_MEM);
    assign wait_ready = in_fetch ? mem.imem_ready : mem.dmem_ready;

    rv_mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .req     (in_fetch || in_mem),
        .ready   (wait_ready),
        .timeout (timeout)
    );

    // Strobes decode straight from state so zero-wait memories cost no extra cycle.
    assign mem.imem_req = !rst && in_fetch;
    assign mem.dmem_req = !rst && in_mem;
    assign mem.dmem_we  = !rst && in_mem && dec_mem_wr;
    assign alu_q_we     = !rst && (state == S_EXECUTE);
    assign mdr_we       = !rst && in_mem && mem.dmem_ready && !dec_mem_wr;
    assign reg_we       = !rst && (state == S_WRITEBACK) && dec_reg_we;
    assign retire       = !rst && ((state == S_WRITEBACK) ||
                                   (in_mem && mem.dmem_ready && dec_mem_wr));
    assign state_o      = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= INST_LENGTH'(NOP_INST);
            trap  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem.imem_ready) begin
                        ir    <= mem.imem_rdata;
                        state <= S_DECODE;
                    end else if (timeout) begin
                        state <= S_TRAP;
                        trap  <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        state <= S_TRAP;
                        trap  <= 1'b1;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: state <= dec_mem_en ? S_MEM : S_WRITEBACK;
                S_MEM: begin
                    if (mem.dmem_ready) begin
                        if (dec_mem_wr) begin
                            pc    <= pc_next;
                            state <= S_FETCH;
                        end else begin
                            state <= S_WRITEBACK;
                        end
                    end else if (timeout) begin
                        state <= S_TRAP;
                        trap  <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    pc    <= pc_next;
                    state <= S_FETCH;
                end
                S_TRAP: state <= S_TRAP;
                default: begin
                    state <= S_TRAP;
                    trap  <= 1'b1;
                end
            endcase
        end
    end

`ifdef RV_MC_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            if (retire) begin
                instret_cnt <= instret_cnt + CNT_WIDTH'(1);
            end
        end
    end
`endif
endmodule

// File: tb/tb_rv_mc_sequencer.sv
// Directed bench for rv_mc_sequencer with a per-instruction expectation scoreboard.
module tb_rv_mc_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_next, pc, ir;
    logic        dec_mem_en, dec_mem_wr, dec_reg_we, dec_illegal;
    logic        alu_q_we, mdr_we, reg_we, retire, trap;
    logic [2:0]  state_o;
`ifdef RV_MC_PERF_COUNTERS_EN
    logic [3:0]  cycle_cnt, instret_cnt;
`endif

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        int          cycles;
        int          reg_we_n;
        int          dreq_n;
        int          dwe_n;
        int          mdr_n;
        logic [31:0] seq;
    } exp_t;
    exp_t sb[$];

    rv_mc_sequencer_if #(.INST_LENGTH(32)) mem ();

    rv_mc_sequencer #(
        .PC_LENGTH(32), .INST_LENGTH(32), .RESET_PC(32'h0),
        .MEM_TIMEOUT(4), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .pc_next(pc_next), .pc(pc), .ir(ir), .mem(mem),
        .dec_mem_en(dec_mem_en), .dec_mem_wr(dec_mem_wr), .dec_reg_we(dec_reg_we),
        .dec_illegal(dec_illegal), .alu_q_we(alu_q_we), .mdr_we(mdr_we),
        .reg_we(reg_we), .retire(retire), .trap(trap), .state_o(state_o)
`ifdef RV_MC_PERF_COUNTERS_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Entered and left just after a falling edge. Acts as IMEM/DMEM and decoder.
    task automatic run_instr(input string tag, input logic [31:0] instr,
                             input logic men, input logic mwr, input logic rwe,
                             input int dly, input logic [31:0] pcn,
                             input int exp_cyc, input int exp_rwe, input int exp_dreq,
                             input int exp_dwe, input int exp_mdr, input logic [31:0] exp_seq);
        exp_t e;
        int cyc = 0, n_rwe = 0, n_dreq = 0, n_dwe = 0, n_mdr = 0, mw = 0;
        logic [31:0] seq = 32'h0;
        logic [2:0]  st;
        bit done = 0;
        sb.push_back('{pc: pcn, ir: instr, cycles: exp_cyc, reg_we_n: exp_rwe,
                       dreq_n: exp_dreq, dwe_n: exp_dwe, mdr_n: exp_mdr, seq: exp_seq});
        mem.imem_rdata = instr;
        pc_next = pcn;
        dec_mem_en = men; dec_mem_wr = mwr; dec_reg_we = rwe; dec_illegal = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            st = state_o;
            mem.imem_ready = (st == 3'd0);
            mem.dmem_ready = (st == 3'd3) && (mw == dly);
            if (st == 3'd3) mw++;
            #1;
            seq = {seq[27:0], 1'b0, st};
            cyc++;
            n_rwe  += int'(reg_we);
            n_dreq += int'(mem.dmem_req);
            n_dwe  += int'(mem.dmem_we);
            n_mdr  += int'(mdr_we);
            if (retire) done = 1;
            @(negedge clk);
        end
        mem.imem_ready = 1'b0;
        mem.dmem_ready = 1'b0;
        e = sb.pop_front();
        check({tag, "_retired"}, 32'(done), 32'd1);
        check({tag, "_cycles"}, cyc, e.cycles);
        check({tag, "_pc"}, pc, e.pc);
        check({tag, "_ir"}, ir, e.ir);
        check({tag, "_reg_we_n"}, n_rwe, e.reg_we_n);
        check({tag, "_dmem_req_n"}, n_dreq, e.dreq_n);
        check({tag, "_dmem_we_n"}, n_dwe, e.dwe_n);
        check({tag, "_mdr_we_n"}, n_mdr, e.mdr_n);
        check({tag, "_states"}, seq, e.seq);
        check({tag, "_back_to_fetch"}, 32'(state_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1; pc_next = 32'h0;
        dec_mem_en = 0; dec_mem_wr = 0; dec_reg_we = 0; dec_illegal = 0;
        mem.imem_ready = 1'b1; mem.imem_rdata = 32'h0; mem.dmem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_ir", ir, 32'h0000_0013);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_imem_req", 32'(mem.imem_req), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        mem.imem_ready = 1'b0; mem.dmem_ready = 1'b0;
        rst = 1'b0;

        // ADDI 0->4, load with 3 wait cycles 4->8, store 8->0x40
        run_instr("addi", 32'h0050_0093, 0, 0, 1, 0, 32'h4,  4, 1, 0, 0, 0, 32'h0000_0124);
        run_instr("load", 32'h0000_A103, 1, 0, 1, 3, 32'h8,  8, 1, 4, 0, 1, 32'h0123_3334);
        run_instr("store", 32'h0020_A023, 1, 1, 0, 0, 32'h40, 4, 0, 1, 1, 0, 32'h0000_0123);

        // IMEM never answers: trap exactly after the 4th wait cycle
        mem.imem_rdata = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        check("to_not_yet", 32'(state_o), 32'd0);
        @(negedge clk);
        check("to_state", 32'(state_o), 32'd7);
        check("to_trap", 32'(trap), 32'd1);
        check("to_pc_hold", pc, 32'h40);
        check("to_imem_req", 32'(mem.imem_req), 32'd0);
        mem.imem_ready = 1'b1; mem.dmem_ready = 1'b1;
        #1;
        check("trap_strobes", {27'h0, mem.imem_req, mem.dmem_req, alu_q_we, reg_we, retire}, 32'h0);
        repeat (3) @(negedge clk);
        check("trap_sticky", 32'(state_o), 32'd7);
        check("trap_ir_hold", ir, 32'h0020_A023);
        mem.imem_ready = 1'b0; mem.dmem_ready = 1'b0;

        // Reset aborts a load stalled in MEM
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem.imem_rdata = 32'h0000_A103;
        dec_mem_en = 1; dec_mem_wr = 0; dec_reg_we = 1; pc_next = 32'h8;
        for (int i = 0; i < 5; i++) begin
            mem.imem_ready = (state_o == 3'd0);
            @(negedge clk);
        end
        mem.imem_ready = 1'b0;
        check("abort_in_mem", 32'(state_o), 32'd3);
        check("abort_dmem_req", 32'(mem.dmem_req), 32'd1);
        rst = 1'b1; mem.dmem_ready = 1'b1;
        #1;
        check("abort_strobes", {27'h0, retire, reg_we, mdr_we, mem.dmem_req, mem.dmem_we}, 32'h0);
        @(negedge clk);
        rst = 1'b0; mem.dmem_ready = 1'b0;
        #1;
        check("abort_imem_req", 32'(mem.imem_req), 32'd1);
        check("abort_pc", pc, 32'h0);
        check("abort_ir", ir, 32'h0000_0013);
        check("abort_trap", 32'(trap), 32'd0);
        @(negedge clk);
        run_instr("addi2", 32'h0010_0113, 0, 0, 1, 0, 32'h4, 4, 1, 0, 0, 0, 32'h0000_0124);

`ifdef RV_MC_PERF_COUNTERS_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("perf_rst_cycle", 32'(cycle_cnt), 32'd0);
        run_instr("p0", 32'h0050_0093, 0, 0, 1, 0, 32'h4, 4, 1, 0, 0, 0, 32'h0000_0124);
        run_instr("p1", 32'h0050_0093, 0, 0, 1, 0, 32'h8, 4, 1, 0, 0, 0, 32'h0000_0124);
        run_instr("p2", 32'h0050_0093, 0, 0, 1, 0, 32'hC, 4, 1, 0, 0, 0, 32'h0000_0124);
        check("perf_instret", 32'(instret_cnt), 32'd3);
        check("perf_cycle12", 32'(cycle_cnt), 32'd12);
        repeat (3) @(negedge clk);
        check("perf_cycle15", 32'(cycle_cnt), 32'd15);
        @(negedge clk);
        check("perf_cycle_wrap", 32'(cycle_cnt), 32'd0);
        check("perf_instret_hold", 32'(instret_cnt), 32'd3);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
